// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request channel plus the decode channel.
// mem_req/mem_ack: request is held with a stable address until the cycle mem_ack is high; mem_data is valid only
// in that cycle. instr_valid/instr_ready: a word transfers in a cycle where both are high; instr holds while waiting.
interface fetch_sequencer_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_valid,
    input  mem_ack, mem_data, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid,
    output mem_ack, mem_data, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: steers pc_unit, issues one memory fetch at a time and hands words to decode,
// with branch redirect, flush of wrong-path fetches, halt and a sticky ack-timeout fault.
module fetch_sequencer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         pc,
  output logic [1:0]          pc_op,
  output logic [15:0]         pc_in,
  output logic                pc_en,
  fetch_sequencer_if.master   bus,
  input  logic                branch_req,
  input  logic [15:0]         branch_target,
  input  logic                halt_req,
  output logic                halted,
  output logic                fetch_fault,
  output logic [2:0]          dbg_state
);

  localparam logic [1:0] PC_NOP   = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_SET   = 2'b10;
  localparam logic [1:0] PC_RESET = 2'b11;

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_ISSUE = 3'd1,
    S_FETCH = 3'd2,
    S_FLUSH = 3'd3,
    S_VALID = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] addr_q;
  logic [15:0] tcnt;
  logic        timeout;

  assign timeout   = (tcnt == TMO_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (halt_req)        state_nxt = S_HALT;
        else if (!branch_req) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (branch_req)      state_nxt = bus.mem_ack ? S_ISSUE : S_FLUSH;
        else if (bus.mem_ack) state_nxt = S_VALID;
        else if (timeout)    state_nxt = S_HALT;
      end
      S_FLUSH: begin
        if (bus.mem_ack)     state_nxt = S_ISSUE;
        else if (timeout)    state_nxt = S_HALT;
      end
      S_VALID: begin
        if (branch_req || bus.instr_ready) state_nxt = S_ISSUE;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  // Outputs are forced idle during rst since the state register only clears on the edge.
  always_comb begin
    pc_op           = PC_NOP;
    pc_in           = branch_target;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = addr_q;
    bus.instr_valid = 1'b0;
    halted          = 1'b0;
    if (!rst) begin
      case (state)
        S_RESET: pc_op = PC_RESET;
        S_ISSUE: if (!halt_req && branch_req) pc_op = PC_SET;
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (branch_req)       pc_op = PC_SET;
          else if (bus.mem_ack) pc_op = PC_INC;
        end
        S_FLUSH: begin
          bus.mem_req = 1'b1;
          if (branch_req) pc_op = PC_SET;
        end
        S_VALID: begin
          bus.instr_valid = !branch_req;
          if (branch_req) pc_op = PC_SET;
        end
        S_HALT:  halted = 1'b1;
        default: pc_op = PC_NOP;
      endcase
    end
  end

  assign pc_en = (pc_op != PC_NOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 16'h0000;
      bus.instr   <= 16'h0000;
      tcnt        <= 16'h0000;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        S_ISSUE: begin
          addr_q <= pc;
          tcnt   <= 16'h0000;
        end
        S_FETCH: begin
          tcnt <= tcnt + 16'h0001;
          if (!branch_req && bus.mem_ack) bus.instr <= bus.mem_data;
          if (!branch_req && !bus.mem_ack && timeout) fetch_fault <= 1'b1;
        end
        S_FLUSH: begin
          tcnt <= tcnt + 16'h0001;
          if (!bus.mem_ack && timeout) fetch_fault <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural pc_unit, a memory/decode driver and an expected-word queue.
module tb_fetch_sequencer;

  localparam logic [1:0] PC_NOP   = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_SET   = 2'b10;
  localparam logic [1:0] PC_RESET = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_q;
  logic [1:0]  pc_op;
  logic [15:0] pc_in;
  logic        pc_en;
  logic        branch_req;
  logic [15:0] branch_target;
  logic        halt_req;
  logic        halted;
  logic        fetch_fault;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] exp_q[$];

  fetch_sequencer_if bus();

  fetch_sequencer #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc_q), .pc_op(pc_op), .pc_in(pc_in), .pc_en(pc_en),
    .bus(bus), .branch_req(branch_req), .branch_target(branch_target),
    .halt_req(halt_req), .halted(halted), .fetch_fault(fetch_fault), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // behavioural pc_unit
  initial pc_q = 16'h1234;
  always @(posedge clk) begin
    if (pc_en) begin
      case (pc_op)
        PC_RESET: pc_q <= 16'h0000;
        PC_INC:   pc_q <= pc_q + 16'h0002;
        PC_SET:   pc_q <= pc_in;
        default:  pc_q <= pc_q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted word must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) chk("unexpected_accept", {16'h0, bus.instr}, 32'hFFFF_FFFF);
      else chk("accepted_word", {16'h0, bus.instr}, {16'h0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic ack, input logic [15:0] data, input logic rdy,
                       input logic br, input logic [15:0] tgt);
    bus.mem_ack     = ack;
    bus.mem_data    = data;
    bus.instr_ready = rdy;
    branch_req      = br;
    branch_target   = tgt;
  endtask

  initial begin
    int req_cycles;
    rst = 1'b1;
    halt_req = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // reset for two cycles
    tick();
    settle();
    chk("rst_pc_op", {30'h0, pc_op}, {30'h0, PC_NOP});
    chk("rst_mem_req", {31'h0, bus.mem_req}, 0);
    chk("rst_valid", {31'h0, bus.instr_valid}, 0);
    chk("rst_instr", {16'h0, bus.instr}, 0);
    chk("rst_fault", {31'h0, fetch_fault}, 0);
    tick();

    // cycle0: RESET
    rst = 1'b0;
    settle();
    chk("c0_pc_op_reset", {30'h0, pc_op}, {30'h0, PC_RESET});
    chk("c0_pc_en", {31'h0, pc_en}, 1);
    tick();
    // cycle1: ISSUE
    settle();
    chk("c1_no_req", {31'h0, bus.mem_req}, 0);
    chk("c1_pc_zero", {16'h0, pc_q}, 0);
    tick();
    // cycle2: FETCH, zero-wait ack
    drive(1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0);
    exp_q.push_back(16'hABCD);
    settle();
    chk("c2_req", {31'h0, bus.mem_req}, 1);
    chk("c2_addr", {16'h0, bus.mem_addr}, 0);
    chk("c2_pc_inc", {30'h0, pc_op}, {30'h0, PC_INC});
    tick();
    // cycle3: VALID, backpressure for four cycles
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_valid", {31'h0, bus.instr_valid}, 1);
      chk("bp_instr", {16'h0, bus.instr}, 16'hABCD);
      chk("bp_pc_nop", {30'h0, pc_op}, {30'h0, PC_NOP});
      chk("bp_pc", {16'h0, pc_q}, 16'h0002);
      tick();
    end
    bus.instr_ready = 1'b1;
    settle();
    tick();
    // ISSUE then FETCH with three wait states
    bus.instr_ready = 1'b0;
    settle();
    chk("iss_no_req", {31'h0, bus.mem_req}, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wait_req", {31'h0, bus.mem_req}, 1);
      chk("wait_addr", {16'h0, bus.mem_addr}, 16'h0002);
      chk("wait_pc_nop", {30'h0, pc_op}, {30'h0, PC_NOP});
      tick();
    end
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
    exp_q.push_back(16'h1111);
    settle();
    chk("wait_ack_addr", {16'h0, bus.mem_addr}, 16'h0002);
    chk("wait_ack_inc", {30'h0, pc_op}, {30'h0, PC_INC});
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    settle();
    chk("w_valid", {31'h0, bus.instr_valid}, 1);
    chk("w_pc_once", {16'h0, pc_q}, 16'h0004);
    tick();
    bus.instr_ready = 1'b0;
    tick();
    // FETCH at 0x0004: branch without ack -> FLUSH
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200);
    settle();
    chk("brf_addr", {16'h0, bus.mem_addr}, 16'h0004);
    chk("brf_set", {30'h0, pc_op}, {30'h0, PC_SET});
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    settle();
    chk("flush_req", {31'h0, bus.mem_req}, 1);
    chk("flush_addr", {16'h0, bus.mem_addr}, 16'h0004);
    tick();
    drive(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0);
    settle();
    chk("flush_ack_addr", {16'h0, bus.mem_addr}, 16'h0004);
    chk("flush_ack_nop", {30'h0, pc_op}, {30'h0, PC_NOP});
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    settle();
    chk("flush_no_valid", {31'h0, bus.instr_valid}, 0);
    chk("flush_iss_no_req", {31'h0, bus.mem_req}, 0);
    tick();
    // FETCH at 0x0200: branch with ack in the same cycle
    settle();
    chk("redir_addr", {16'h0, bus.mem_addr}, 16'h0200);
    drive(1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h0300);
    settle();
    chk("bra_set_not_inc", {30'h0, pc_op}, {30'h0, PC_SET});
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    settle();
    chk("bra_issue_no_req", {31'h0, bus.mem_req}, 0);
    chk("bra_no_valid", {31'h0, bus.instr_valid}, 0);
    chk("bra_pc", {16'h0, pc_q}, 16'h0300);
    tick();
    settle();
    chk("bra_next_addr", {16'h0, bus.mem_addr}, 16'h0300);
    drive(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0);
    tick();
    // VALID: branch masks instr_valid even with instr_ready high
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0100);
    settle();
    chk("brv_instr", {16'h0, bus.instr}, 16'h5555);
    chk("brv_masked", {31'h0, bus.instr_valid}, 0);
    chk("brv_set", {30'h0, pc_op}, {30'h0, PC_SET});
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    settle();
    chk("brv_next_addr", {16'h0, bus.mem_addr}, 16'h0100);
    // redirect to 0xFFFE for the wrap case
    drive(1'b1, 16'h0, 1'b1, 1'b1, 16'hFFFE);
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    settle();
    chk("wrap_addr", {16'h0, bus.mem_addr}, 16'hFFFE);
    drive(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0);
    exp_q.push_back(16'h7777);
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    settle();
    chk("wrap_pc", {16'h0, pc_q}, 16'h0000);
    chk("wrap_instr", {16'h0, bus.instr}, 16'h7777);
    tick();
    tick();
    settle();
    chk("wrap_next_addr", {16'h0, bus.mem_addr}, 16'h0000);
    chk("wrap_next_req", {31'h0, bus.mem_req}, 1);
    // no ack: request must stay high exactly ACK_TIMEOUT cycles
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (bus.mem_req) req_cycles++;
      if (i == 6) branch_req = 1'b1;
      tick();
    end
    settle();
    chk("tmo_req_cycles", req_cycles, 4);
    chk("tmo_fault", {31'h0, fetch_fault}, 1);
    chk("tmo_halted", {31'h0, halted}, 1);
    chk("tmo_req_low", {31'h0, bus.mem_req}, 0);
    chk("halt_ignores_branch", {30'h0, pc_op}, {30'h0, PC_NOP});
    chk("halt_dbg_state", {29'h0, dbg_state}, 5);
    branch_req = 1'b0;
    // reset clears fault and halt, then halt_req in ISSUE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("clr_fault", {31'h0, fetch_fault}, 0);
    chk("clr_halted", {31'h0, halted}, 0);
    tick();
    halt_req = 1'b1;
    branch_req = 1'b1;
    settle();
    chk("hreq_no_req", {31'h0, bus.mem_req}, 0);
    chk("hreq_over_branch", {30'h0, pc_op}, {30'h0, PC_NOP});
    tick();
    halt_req = 1'b0;
    branch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hreq_halted", {31'h0, halted}, 1);
      chk("hreq_idle", {31'h0, bus.mem_req}, 0);
      tick();
    end
    chk("hreq_no_fault", {31'h0, fetch_fault}, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences pc_unit. It drives pc_op/pc_in/en for pc_unit, issues 16-bit fetch requests to instruction memory over a req/ack handshake, and presents fetched words to decode over a valid/ready handshake. It also handles branch redirects, flushes of in-flight wrong-path fetches, halt, and an ack timeout.

Parameters:
ACK_TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before a fault (1..65535)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
pc  in  16  current PC (pc_unit pc_out)
pc_op  out  2  to pc_unit, `PC_* encodings from cpu_constants.vh
pc_in  out  16  to pc_unit, branch target
pc_en  out  1  to pc_unit en; high exactly when pc_op != `PC_NOP
mem_req  out  1  fetch request, held until mem_ack
mem_addr  out  16  fetch address, stable while mem_req high
mem_ack  in  1  fetch complete, mem_data valid this cycle
mem_data  in  16  fetched word
instr  out  16  registered instruction word
instr_valid  out  1  instr valid to decode
instr_ready  in  1  decode accepts instr
branch_req  in  1  redirect request, one-cycle pulse
branch_target  in  16  redirect PC
halt_req  in  1  stop fetching
halted  out  1  in HALT state
fetch_fault  out  1  sticky ack-timeout flag

Behaviour:
- States: RESET, ISSUE, FETCH, FLUSH, VALID, HALT. Registers: state, addr_q[15:0], instr[15:0], tcnt[15:0], fetch_fault.
- rst=1 (any state, including mid-fetch): state<=RESET, instr<=0, addr_q<=0, tcnt<=0, fetch_fault<=0. Outputs during rst: pc_op=`PC_NOP, pc_en=0, mem_req=0, instr_valid=0, halted=0. No outstanding request is honoured after reset.
- Defaults: pc_op=`PC_NOP, pc_in=branch_target, mem_req=0, mem_addr=addr_q.
- RESET: pc_op=`PC_RESET for 1 cycle, then ISSUE. branch_req is ignored.
- ISSUE: addr_q<=pc, tcnt<=0.
  - If halt_req=1: go to HALT. halt_req takes priority over branch_req.
  - Else if branch_req=1: pc_op=`PC_SET, stay in ISSUE. pc updates next cycle and is recaptured then.
  - Else go to FETCH.
- FETCH: mem_req=1, tcnt increments each cycle.
  - If branch_req=1: pc_op=`PC_SET. Go to FLUSH if mem_ack=0, or to ISSUE if mem_ack=1. Data is discarded.
  - Else if mem_ack=1: instr<=mem_data, pc_op=`PC_INC (pc+2, 16-bit wrap, 16'hFFFE -> 16'h0000), go to VALID.
  - Else if tcnt==ACK_TIMEOUT-1: fetch_fault<=1, go to HALT.
- FLUSH: mem_req=1, mem_addr=addr_q (old address), tcnt increments.
  - On mem_ack: discard data, go to ISSUE.
  - A branch_req in FLUSH: pc_op=`PC_SET, stay in FLUSH (last target wins).
  - Timeout rule is the same as in FETCH.
- VALID: instr_valid = !branch_req (combinational mask: a wrong-path word is never accepted).
  - If branch_req=1: pc_op=`PC_SET, go to ISSUE. instr is dropped even if instr_ready=1.
  - Else if instr_ready=1: go to ISSUE.
  - Else hold; instr stays stable.
- HALT: halted=1, mem_req=0, pc_op=`PC_NOP. Exit only via rst. branch_req and halt_req are ignored.
- Latency: ISSUE to mem_req is 1 cycle. mem_ack to instr_valid is 1 cycle. Steady state with zero-wait memory and instr_ready=1 gives one instruction per 3 cycles (ISSUE, FETCH, VALID).
- mem_req never drops before mem_ack, except on rst or timeout. mem_addr never changes while mem_req=1.
- pc_op is never `PC_INC and `PC_SET in the same cycle; branch wins.

Test Plan:
- Reset/first fetch: rst high 2 cycles then low; mem_ack in the first mem_req cycle with mem_data=16'hABCD -> cycle0 pc_op=`PC_RESET; cycle2 mem_req=1, mem_addr=0; cycle3 instr=16'hABCD, instr_valid=1, pc=2.
- Backpressure/wait states: mem_ack delayed 3 cycles and instr_ready low 4 cycles -> mem_req and mem_addr held stable throughout; instr_valid held; exactly one `PC_INC; next fetch at mem_addr=2.
- Branch in VALID: instr_valid=1, branch_req=1, branch_target=16'h0100, instr_ready=1 -> instr_valid=0 that cycle, pc_op=`PC_SET; next mem_addr=16'h0100.
- Branch in FETCH, no ack: branch_target=16'h0200 while mem_addr=16'h0004 -> FLUSH keeps mem_addr=16'h0004 until ack, data dropped, no instr_valid; next request mem_addr=16'h0200. Repeat with ack in the same cycle as the branch -> goes straight to ISSUE, no `PC_INC.
- Wrap: pc=16'hFFFE, fetch acked -> pc becomes 16'h0000, next mem_addr=16'h0000.
- Timeout/halt: ACK_TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then fetch_fault=1, halted=1, mem_req=0. rst clears both. Separately, halt_req=1 in ISSUE -> halted=1 with no request issued.
